// File: rtl/fb_double_buffer.sv
// Double-buffered 1-bit framebuffer. Drawing writes land in the back bank, scanout reads the
// front bank through a two-stage pipeline, and a requested swap is deferred to the next vblank.
// Optional feature: define FB_AUTO_CLEAR_EN to zero the new back bank after every swap.
module fb_double_buffer #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 1280,
    parameter int unsigned VER_ACTIVE_PIXELS = 720
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [20:0] wr_addr,
    input  logic        wr_data,
    output logic        wr_ready,
    input  logic        swap_req,
    input  logic        vblank_start,
    input  logic        rd_en,
    input  logic [10:0] rd_x,
    input  logic [10:0] rd_y,
    output logic        pixel,
    output logic        swap_pending,
    output logic        swap_done,
    output logic        front_sel
);

    localparam int unsigned N  = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StPending
`ifdef FB_AUTO_CLEAR_EN
        , StClear
`endif
    } state_e;

    state_e state_q, state_d;
    logic   front_sel_q, front_sel_d;
    logic   swap_done_q, swap_done_d;
    logic   do_swap;

`ifdef FB_AUTO_CLEAR_EN
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

    // Storage banks; contents are never reset.
    logic mem0_q [N];
    logic mem1_q [N];

    // Read pipeline registers
    logic          rd_vld_q;
    logic [AW-1:0] rd_addr_q;
    logic          rd_bank_q;
    logic          pixel_q;
    logic [31:0]   rd_lin;

    // Write port selection
    logic          wr_we;
    logic          wr_bank;
    logic [AW-1:0] wr_idx;
    logic          wr_bit;

    // Next-state logic for the swap controller (and clear sequencer when enabled).
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        do_swap     = 1'b0;
`ifdef FB_AUTO_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                // A swap request coinciding with vblank is served at once.
                if (swap_req) begin
                    if (vblank_start) do_swap = 1'b1;
                    else              state_d = StPending;
                end
            end
            StPending: begin
                if (vblank_start) do_swap = 1'b1;
            end
`ifdef FB_AUTO_CLEAR_EN
            StClear: begin
                if (clr_cnt_q == AW'(N - 1)) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (do_swap) begin
            front_sel_d = ~front_sel_q;
`ifdef FB_AUTO_CLEAR_EN
            state_d     = StClear;
            clr_cnt_d   = '0;
`else
            state_d     = StIdle;
`endif
        end
        swap_done_d = do_swap;
    end

    // Controller state registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
`ifdef FB_AUTO_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
`ifdef FB_AUTO_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

`ifdef FB_AUTO_CLEAR_EN
    assign wr_ready = (state_q != StClear);
`else
    assign wr_ready = 1'b1;
`endif

    // Write port mux: drawing writes normally, clear sequencer while clearing.
    // The target bank uses the pre-edge front_sel so a same-cycle swap hits the old back bank.
    always_comb begin
        wr_bank = ~front_sel_q;
        wr_we   = !rst && wr_en && wr_ready && ({11'd0, wr_addr} < N);
        wr_idx  = wr_addr[AW-1:0];
        wr_bit  = wr_data;
`ifdef FB_AUTO_CLEAR_EN
        if (state_q == StClear) begin
            wr_we  = !rst;
            wr_idx = clr_cnt_q;
            wr_bit = 1'b0;
        end
`endif
    end

    // Bank write ports
    always_ff @(posedge clk) begin
        if (wr_we && !wr_bank) mem0_q[wr_idx] <= wr_bit;
        if (wr_we &&  wr_bank) mem1_q[wr_idx] <= wr_bit;
    end

    assign rd_lin = 32'(rd_y) * 32'(HOR_ACTIVE_PIXELS) + 32'(rd_x);

    // Read stage 1: register address, validity and the bank being scanned right now.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en && (rd_lin < N);
            rd_addr_q <= rd_lin[AW-1:0];
            rd_bank_q <= front_sel_q;
        end
    end

    // Read stage 2: memory read, forced to 0 for idle or out-of-range requests.
    always_ff @(posedge clk) begin
        if (rst)           pixel_q <= 1'b0;
        else if (rd_vld_q) pixel_q <= rd_bank_q ? mem1_q[rd_addr_q] : mem0_q[rd_addr_q];
        else               pixel_q <= 1'b0;
    end

    assign pixel        = pixel_q;
    assign swap_pending = (state_q == StPending);
    assign swap_done    = swap_done_q;
    assign front_sel    = front_sel_q;

endmodule

// File: tb/tb_fb_double_buffer.sv
// Directed bench for fb_double_buffer on an 8x4 framebuffer (N = 32).
// Define FB_AUTO_CLEAR_EN for both bench and RTL to exercise the auto-clear build.
module tb_fb_double_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [20:0] wr_addr;
    logic        wr_data;
    logic        wr_ready;
    logic        swap_req;
    logic        vblank_start;
    logic        rd_en;
    logic [10:0] rd_x;
    logic [10:0] rd_y;
    logic        pixel;
    logic        swap_pending;
    logic        swap_done;
    logic        front_sel;

    int n_tests = 0;
    int n_fail  = 0;

    fb_double_buffer #(
        .HOR_ACTIVE_PIXELS(8),
        .VER_ACTIVE_PIXELS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .swap_req     (swap_req),
        .vblank_start (vblank_start),
        .rd_en        (rd_en),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .pixel        (pixel),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .front_sel    (front_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int addr, input logic d);
        wr_en   = 1'b1;
        wr_addr = 21'(addr);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_px(input int x, input int y, output logic p);
        rd_x  = 11'(x);
        rd_y  = 11'(y);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        p = pixel;
    endtask

    task automatic swap_now();
        swap_req     = 1'b1;
        vblank_start = 1'b1;
        tick();
        swap_req     = 1'b0;
        vblank_start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        check_eq("wr_ready_returns", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic p;
        int   cnt;
        int   ones;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
        swap_req = 1'b0; vblank_start = 1'b0; rd_en = 1'b0; rd_x = '0; rd_y = '0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_front_sel", 32'(front_sel), 32'd0);
        check_eq("rst_pending",   32'(swap_pending), 32'd0);
        check_eq("rst_done",      32'(swap_done), 32'd0);
        check_eq("rst_pixel",     32'(pixel), 32'd0);
        check_eq("rst_wr_ready",  32'(wr_ready), 32'd1);

        // Basic write, deferred swap, read back from the new front bank.
        write_px(5, 1'b1);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        check_eq("req_pending", 32'(swap_pending), 32'd1);
        check_eq("req_front_hold", 32'(front_sel), 32'd0);
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        check_eq("swap1_front", 32'(front_sel), 32'd1);
        check_eq("swap1_done", 32'(swap_done), 32'd1);
        check_eq("swap1_pending_clr", 32'(swap_pending), 32'd0);
        tick();
        check_eq("swap1_done_pulse", 32'(swap_done), 32'd0);
        wait_ready();
        read_px(5, 0, p);
        check_eq("read_5_0", 32'(p), 32'd1);
        tick();
        check_eq("read_idle_zero", 32'(pixel), 32'd0);

        // Pending without vblank stays pending; second request ignored.
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check_eq("hold_pending", 32'(swap_pending), 32'd1);
        check_eq("hold_front", 32'(front_sel), 32'd1);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        check_eq("rereq_pending", 32'(swap_pending), 32'd1);
        check_eq("rereq_front", 32'(front_sel), 32'd1);
        check_eq("rereq_no_done", 32'(swap_done), 32'd0);
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        check_eq("swap2_front", 32'(front_sel), 32'd0);
        check_eq("swap2_done", 32'(swap_done), 32'd1);
        wait_ready();

        // Request and vblank together swap at that edge.
        swap_now();
        check_eq("same_cyc_front", 32'(front_sel), 32'd1);
        check_eq("same_cyc_done", 32'(swap_done), 32'd1);
        check_eq("same_cyc_pending", 32'(swap_pending), 32'd0);
        tick();
        check_eq("same_cyc_done_off", 32'(swap_done), 32'd0);
        wait_ready();

        // vblank while idle does nothing.
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        check_eq("idle_vblank_front", 32'(front_sel), 32'd1);
        check_eq("idle_vblank_done", 32'(swap_done), 32'd0);

        // Out-of-range write dropped; out-of-range read returns 0. Back bank is bank 0.
        write_px(0, 1'b0);
        write_px(1, 1'b1);
        write_px(32, 1'b1);
        swap_now();
        check_eq("oor_front", 32'(front_sel), 32'd0);
        wait_ready();
        read_px(0, 0, p);
        check_eq("oor_write_dropped", 32'(p), 32'd0);
        read_px(1, 0, p);
        check_eq("read_1_0", 32'(p), 32'd1);
        read_px(1, 4, p);
        check_eq("oor_read_zero", 32'(p), 32'd0);
        read_px(0, 4, p);
        check_eq("oor_read_0_4", 32'(p), 32'd0);

        // Read in flight across a swap uses the bank sampled in stage 1 (bank 0).
        write_px(1, 1'b0);
        write_px(2, 1'b0);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        rd_x = 11'd1; rd_y = 11'd0; rd_en = 1'b1; vblank_start = 1'b1;
        tick();
        rd_en = 1'b0; vblank_start = 1'b0;
        check_eq("inflight_front", 32'(front_sel), 32'd1);
        tick();
        check_eq("inflight_pixel", 32'(pixel), 32'd1);
        wait_ready();

        // Write coinciding with the swap lands in the old back bank (bank 0).
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        wr_en = 1'b1; wr_addr = 21'd2; wr_data = 1'b1; vblank_start = 1'b1;
        tick();
        wr_en = 1'b0; vblank_start = 1'b0;
        check_eq("wr_swap_front", 32'(front_sel), 32'd0);
        wait_ready();
        read_px(2, 0, p);
        check_eq("wr_swap_bank", 32'(p), 32'd1);

`ifdef FB_AUTO_CLEAR_EN
        // Fill bank 1, swap: bank 0 is cleared over exactly 32 cycles.
        for (int a = 0; a < 32; a++) write_px(a, 1'b1);
        swap_now();
        check_eq("clr_front", 32'(front_sel), 32'd1);
        cnt = 0;
        while (!wr_ready && cnt < 200) begin
            cnt++;
            tick();
        end
        check_eq("clr_cycles", 32'(cnt), 32'd32);
        swap_now();
        check_eq("clr_front2", 32'(front_sel), 32'd0);
        wait_ready();
        ones = 0;
        for (int a = 0; a < 32; a++) begin
            read_px(a % 8, a / 8, p);
            if (p === 1'b1) ones++;
        end
        check_eq("clr_all_zero", 32'(ones), 32'd0);

        // Reset ten cycles into a clear aborts it.
        swap_now();
        for (int i = 0; i < 10; i++) tick();
        check_eq("mid_clr_busy", 32'(wr_ready), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("clr_rst_ready", 32'(wr_ready), 32'd1);
        check_eq("clr_rst_front", 32'(front_sel), 32'd0);
        check_eq("clr_rst_pending", 32'(swap_pending), 32'd0);
        check_eq("clr_rst_pixel", 32'(pixel), 32'd0);
`endif

        // Reset beats a simultaneous swap and read.
        rst = 1'b1; swap_req = 1'b1; vblank_start = 1'b1; rd_en = 1'b1; rd_x = 11'd2; rd_y = '0;
        tick();
        rst = 1'b0; swap_req = 1'b0; vblank_start = 1'b0; rd_en = 1'b0;
        check_eq("rst_prio_front", 32'(front_sel), 32'd0);
        check_eq("rst_prio_done", 32'(swap_done), 32'd0);
        tick();
        check_eq("rst_prio_done2", 32'(swap_done), 32'd0);
        check_eq("rst_prio_pixel", 32'(pixel), 32'd0);
        check_eq("rst_prio_pending", 32'(swap_pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_double_buffer.md
FB_DOUBLE_BUFFER -- requirements
Module: fb_double_buffer

Interface
REQ-001 Parameter HOR_ACTIVE_PIXELS, default 1280, framebuffer width in pixels.
REQ-002 Parameter VER_ACTIVE_PIXELS, default 720, framebuffer height in pixels; N = HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS.
REQ-003 Clock and reset are decided: reset rst, synchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock for all logic.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  pixel write strobe from drawing stage.
REQ-007 wr_addr  input  21  linear pixel address, y*HOR_ACTIVE_PIXELS+x.
REQ-008 wr_data  input  1  pixel colour.
REQ-009 wr_ready  output  1  high when writes are accepted; drawing stage uses it as clock enable.
REQ-010 swap_req  input  1  one-cycle request to present the back buffer.
REQ-011 vblank_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-012 rd_en  input  1  scanout pixel request (active video).
REQ-013 rd_x, rd_y  input  11 each  scanout coordinates.
REQ-014 pixel  output  1  scanout pixel colour.
REQ-015 swap_pending  output  1  swap requested, not yet performed.
REQ-016 swap_done  output  1  one-cycle pulse on the cycle after a swap.
REQ-017 front_sel  output  1  bank currently scanned out (0 or 1).

Function
REQ-018 Two internal 1-bit banks of N entries each, synchronous read, synchronous write; contents not reset.
REQ-019 Writes go only to bank !front_sel, when wr_en=1, wr_ready=1 and wr_addr<N; otherwise dropped.
REQ-020 Reads come only from bank front_sel; address rd_y*HOR_ACTIVE_PIXELS+rd_x registered in stage 1, memory read in stage 2.
REQ-021 pixel is valid exactly 2 cycles after rd_en sample; pixel=0 when the rd_en sampled 2 cycles earlier was 0 or the computed address was >=N.
REQ-022 States: IDLE, PENDING, CLEAR (CLEAR exists only per REQ-033).
REQ-023 IDLE: swap_req -> PENDING; swap_pending=1 from the next cycle.
REQ-024 PENDING: vblank_start -> toggle front_sel, clear swap_pending, pulse swap_done next cycle, go IDLE (or CLEAR per REQ-033).
REQ-025 swap_req and vblank_start in the same cycle in IDLE: swap performed at that edge, no extra vblank wait.
REQ-026 swap_req while PENDING or CLEAR: ignored, no queueing.
REQ-027 vblank_start in IDLE: no effect.
REQ-028 A read pipeline in flight across a swap completes from the bank sampled in stage 1.
REQ-029 Write to an address in the same cycle as a swap targets the bank that was back before the edge.

Reset
REQ-030 On rst: state IDLE, front_sel=0, swap_pending=0, swap_done=0, pixel=0, wr_ready=1, read pipeline valid bits 0, clear counter 0.
REQ-031 rst mid-CLEAR aborts the clear immediately; partially cleared bank left as is.
REQ-032 rst has priority over all other inputs in the same cycle.

Configuration
REQ-033 Macro FB_AUTO_CLEAR_EN defined: after each swap enter CLEAR, write 0 to new back bank addresses 0..N-1 one per cycle (N cycles), wr_ready=0 throughout, drawing writes dropped, return IDLE after address N-1; vblank_start in CLEAR ignored; swap_req in CLEAR ignored.
REQ-034 FB_AUTO_CLEAR_EN undefined: no CLEAR state, no clear counter, wr_ready tied 1, swap goes PENDING -> IDLE.

Verification
REQ-035 HOR=8, VER=4: write addr 5 data 1, swap_req, vblank_start, rd_en at (5,0) -> pixel=1 two cycles later, front_sel=1, swap_done one pulse.
REQ-036 swap_req with no vblank_start for 100 cycles -> swap_pending stays 1, front_sel unchanged; second swap_req -> no change.
REQ-037 swap_req and vblank_start same cycle -> front_sel toggles that edge, swap_done next cycle.
REQ-038 wr_addr=32 (=N) wr_data=1 -> no bank changes; rd (0,4) -> pixel=0.
REQ-039 FB_AUTO_CLEAR_EN, bank filled with 1s, swap -> wr_ready low exactly 32 cycles, after second swap all 32 pixels read 0.
REQ-040 rst asserted 10 cycles into CLEAR -> next cycle wr_ready=1, front_sel=0, swap_pending=0, pixel=0.
